vga_clk_rst_mux: RTL and testbench
==================================

Name: vga_clk_rst_mux

Overview:
Front-end utility block for the VGA controller. It unifies three functions:
- pixel-clock divider (vga_clk_div function);
- reset synchroniser aligned to the pixel clock (rst_sync function);
- final colour selector/blanker (vga_colr_mux function).

The whole block runs from the single top clock. It feeds the pixel counter, timing controller and the DAC-side colour outputs.

Parameters:
REF_CLK_FREQ_HZ  100_000_000  frequency of clk_i
PX_CLK_FREQ_HZ  25_000_000  target pixel clock frequency
SYNC_STAGES  3  number of pixel-clock rising edges needed to release sync_rstn_o (>=2)
PXL_WIDTH  1  bits per pixel (1 = mono; 3*colour depth for RGB)

Ports:
clk_i  in  1  top clock; the only clock in the block
rstn_i  in  1  reset, synchronous to clk_i, active-low
clk_px_o  out  1  divided pixel clock, 50% duty, registered
px_stb_o  out  1  one-clk_i-cycle strobe; high in the cycle before each clk_px_o rising edge
sync_rstn_o  out  1  synchronised active-low reset for the pixel domain
test_colr_i  in  PXL_WIDTH  test-pattern colour
mem_colr_i  in  PXL_WIDTH  frame-memory colour
en_i  in  1  source select: 1 = test pattern, 0 = memory
blank_i  in  1  colour-valid qualifier from the timing controller: 1 = drive colour, 0 = blank
colr_o  out  PXL_WIDTH  colour to display

Behaviour:
Interface: one clock (clk_i); reset is synchronous and active-low (rstn_i). All state updates on rising clk_i only.

Divider:
- DIV = REF_CLK_FREQ_HZ / PX_CLK_FREQ_HZ; must be an even integer >= 2.
- HALF = DIV/2. Counter width = max(1, clog2(HALF)). Violation is an elaboration error (fatal assertion).
- Reset (rstn_i=0 at edge): cnt <= 0, clk_px_o <= 0.
- Otherwise at each edge:
  - if cnt == HALF-1: cnt <= 0 and clk_px_o <= ~clk_px_o;
  - else cnt <= cnt+1.
- With defaults (HALF=2): clk_px_o rises on the 2nd clk_i edge after reset release, then toggles every 2 edges. Period is 4 clk_i cycles.
- px_stb_o = (cnt == HALF-1) && !clk_px_o && rstn_i. This is combinational from registers plus rstn_i, and is 0 during reset.
- Exactly one strobe per pixel period.

Reset synchroniser:
- State is a SYNC_STAGES-bit shift register sr.
- rstn_i=0 at edge: sr <= all 0. Assertion takes effect on the first clk_i edge with rstn_i low, including mid-operation.
- rstn_i=1 and px_stb_o=1 at edge: sr <= {sr[SYNC_STAGES-2:0], 1'b1}.
- Otherwise sr holds.
- sync_rstn_o = sr[SYNC_STAGES-1].
- Release occurs on the clk_i edge coinciding with the SYNC_STAGES-th pixel-clock rising edge after rstn_i goes high, so it is always aligned to a clk_px_o rising edge.
- Reset pulse shorter than one clk_i cycle: not sampled; no requirement.

Colour mux (purely combinational, no reset dependence):
- blank_i=0 -> colr_o = 0 (all bits).
- blank_i=1 and en_i=1 -> colr_o = test_colr_i.
- blank_i=1 and en_i=0 -> colr_o = mem_colr_i.
- Blanking has priority over source select.
- X on an unselected input must not propagate to colr_o.

Reset values: clk_px_o=0, px_stb_o=0, sync_rstn_o=0. colr_o follows its inputs even during reset.

Test Plan:
1. Defaults; hold rstn_i=0 for 10 clk_i cycles, then release -> clk_px_o=0 and sync_rstn_o=0 throughout reset; clk_px_o rises at edge 2 after release, period 4 cycles, high exactly 2 cycles.
2. Same run -> px_stb_o high exactly in cycles 1, 5, 9... after release; sync_rstn_o rises on the 3rd clk_px_o rising edge (edge 10 after release) and coincides with it.
3. Pull rstn_i low for 1 cycle mid-operation -> next edge: clk_px_o=0, sync_rstn_o=0, cnt=0. After release the full 10-edge release sequence repeats.
4. REF=100e6, PX=50e6 (HALF=1) -> clk_px_o toggles every edge; px_stb_o every other cycle. REF=100e6, PX=30e6 -> elaboration failure.
5. Mux sweep with PXL_WIDTH=3, test=3'b101, mem=3'b010:
   - blank_i=0 -> 000 for both en_i values;
   - blank_i=1, en_i=1 -> 101;
   - blank_i=1, en_i=0 -> 010;
   - mem=X with en_i=1 -> 101 with no X.
6. SYNC_STAGES=5, defaults otherwise -> sync_rstn_o releases on the 5th pixel rising edge (edge 18 after rstn_i release).

Source files
------------

// File: rtl/vga_clk_rst_mux.sv
// VGA front-end utility block: pixel-clock divider, reset synchroniser
// aligned to the divided pixel clock, and the final colour selector/blanker.
// Everything runs from clk_i; clk_px_o is a registered divided clock and
// px_stb_o is the matching one-cycle enable for logic that stays on clk_i.
module vga_clk_rst_mux #(
    parameter int unsigned REF_CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PX_CLK_FREQ_HZ  = 25_000_000,
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned PXL_WIDTH       = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    output logic                 clk_px_o,
    output logic                 px_stb_o,
    output logic                 sync_rstn_o,
    input  logic [PXL_WIDTH-1:0] test_colr_i,
    input  logic [PXL_WIDTH-1:0] mem_colr_i,
    input  logic                 en_i,
    input  logic                 blank_i,
    output logic [PXL_WIDTH-1:0] colr_o
);

    // Divider geometry. The pixel clock toggles every HALF reference cycles,
    // so the ratio has to be an even integer for a 50% duty output.
    localparam int unsigned DIV   = (PX_CLK_FREQ_HZ == 0) ? 0 : REF_CLK_FREQ_HZ / PX_CLK_FREQ_HZ;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (HALF <= 1) ? 1 : $clog2(HALF);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    // Bad frequency ratios or a too-short synchroniser stop elaboration.
    if (PX_CLK_FREQ_HZ == 0 || (REF_CLK_FREQ_HZ % PX_CLK_FREQ_HZ) != 0 ||
        DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $fatal(1, "vga_clk_rst_mux: REF_CLK_FREQ_HZ/PX_CLK_FREQ_HZ must be an even integer >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "vga_clk_rst_mux: SYNC_STAGES must be >= 2");
    end
    if (PXL_WIDTH < 1) begin : g_bad_pxl
        $fatal(1, "vga_clk_rst_mux: PXL_WIDTH must be >= 1");
    end

    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   clk_px_q, clk_px_d;
    logic [SYNC_STAGES-1:0] sr_q,     sr_d;
    logic                   wrap;
    logic                   px_stb;

    assign wrap = (cnt_q == CNT_MAX);

    // The strobe flags the reference cycle just before clk_px_o rises; rstn_i
    // gates it so nothing downstream sees an enable while reset is applied.
    assign px_stb = wrap && !clk_px_q && rstn_i;

    // Next-state for the divider counter, pixel clock and reset shift register.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d    = cnt_q + 1'b1;
        clk_px_d = clk_px_q;
        sr_d     = sr_q;
        if (wrap) begin
            cnt_d    = '0;
            clk_px_d = ~clk_px_q;
        end
        // Shifting only on the strobe makes every release land on a pixel
        // clock rising edge.
        if (px_stb) begin
            sr_d = {sr_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // State registers with synchronous active-low reset; reset assertion wins
    // on the first edge it is seen, even mid-frame.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from their pre-edge values.
        if (!rstn_i) begin
            cnt_q    <= '0;
            clk_px_q <= 1'b0;
            sr_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            clk_px_q <= clk_px_d;
            sr_q     <= sr_d;
        end
    end

    // Colour selection: blanking overrides the source select, and only the
    // selected source reaches the output so an unknown on the other is hidden.
    always_comb begin
        colr_o = '0;
        if (blank_i) begin
            if (en_i) begin
                colr_o = test_colr_i;
            end else begin
                colr_o = mem_colr_i;
            end
        end
    end

    assign clk_px_o    = clk_px_q;
    assign px_stb_o    = px_stb;
    assign sync_rstn_o = sr_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_vga_clk_rst_mux.sv
// Directed bench for vga_clk_rst_mux. Three instances share clk and rstn:
//   u_def  : default parameters (HALF=2, 3 sync stages, mono)
//   u_fast : 50 MHz pixel clock (HALF=1)
//   u_s5   : 5 sync stages, 3-bit colour
// Cycle k means the interval after the k-th clk rising edge that saw rstn=1.
module tb_vga_clk_rst_mux;

    logic clk = 1'b0;
    logic rstn;

    // mono colour inputs shared by u_def and u_fast
    logic       test1, mem1, en1, blank1;
    logic       colr_def, colr_fast;
    // 3-bit colour inputs for u_s5
    logic [2:0] test3, mem3;
    logic       en3, blank3;
    logic [2:0] colr_s5;

    logic clk_px_def, stb_def, srst_def;
    logic clk_px_fast, stb_fast, srst_fast;
    logic clk_px_s5, stb_s5, srst_s5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_clk_rst_mux u_def (
        .clk_i(clk), .rstn_i(rstn),
        .clk_px_o(clk_px_def), .px_stb_o(stb_def), .sync_rstn_o(srst_def),
        .test_colr_i(test1), .mem_colr_i(mem1), .en_i(en1), .blank_i(blank1),
        .colr_o(colr_def)
    );

    vga_clk_rst_mux #(.REF_CLK_FREQ_HZ(100_000_000), .PX_CLK_FREQ_HZ(50_000_000)) u_fast (
        .clk_i(clk), .rstn_i(rstn),
        .clk_px_o(clk_px_fast), .px_stb_o(stb_fast), .sync_rstn_o(srst_fast),
        .test_colr_i(test1), .mem_colr_i(mem1), .en_i(en1), .blank_i(blank1),
        .colr_o(colr_fast)
    );

    vga_clk_rst_mux #(.SYNC_STAGES(5), .PXL_WIDTH(3)) u_s5 (
        .clk_i(clk), .rstn_i(rstn),
        .clk_px_o(clk_px_s5), .px_stb_o(stb_s5), .sync_rstn_o(srst_s5),
        .test_colr_i(test3), .mem_colr_i(mem3), .en_i(en3), .blank_i(blank3),
        .colr_o(colr_s5)
    );

    // advance one clk edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all three instances for 20 cycles after rstn goes high.
    // Hand-derived timing (HALF=2): clk_px rises at edges 2,6,10,...;
    // strobe in cycles 1,5,9,...; sync release at the 3rd rise (edge 10)
    // or the 5th rise (edge 18). HALF=1: clk_px high after odd edges,
    // strobe after even edges, sync release at edge 5 (rises 1,3,5).
    task automatic run_release_seq(input string tag);
        logic e_px, e_stb, e_srst;
        rstn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_px   = (k >= 2) && (((k - 2) % 4) < 2);
            e_stb  = ((k % 4) == 1);
            e_srst = (k >= 10);
            n_tests++;
            if (clk_px_def !== e_px) begin
                n_fail++;
                $display("FAIL %s def clk_px cyc%0d got %b exp %b", tag, k, clk_px_def, e_px);
            end
            n_tests++;
            if (stb_def !== e_stb) begin
                n_fail++;
                $display("FAIL %s def px_stb cyc%0d got %b exp %b", tag, k, stb_def, e_stb);
            end
            n_tests++;
            if (srst_def !== e_srst) begin
                n_fail++;
                $display("FAIL %s def sync_rstn cyc%0d got %b exp %b", tag, k, srst_def, e_srst);
            end
            n_tests++;
            if (clk_px_s5 !== e_px || stb_s5 !== e_stb || srst_s5 !== (k >= 18)) begin
                n_fail++;
                $display("FAIL %s s5 px/stb/srst cyc%0d got %b%b%b exp %b%b%b", tag, k,
                         clk_px_s5, stb_s5, srst_s5, e_px, e_stb, (k >= 18));
            end
            n_tests++;
            if (clk_px_fast !== (k % 2 == 1) || stb_fast !== (k % 2 == 0) ||
                srst_fast !== (k >= 5)) begin
                n_fail++;
                $display("FAIL %s fast px/stb/srst cyc%0d got %b%b%b exp %b%b%b", tag, k,
                         clk_px_fast, stb_fast, srst_fast, (k % 2 == 1), (k % 2 == 0), (k >= 5));
            end
        end
    endtask

    // All register outputs and the strobe stay low while reset is held.
    task automatic test_reset();
        rstn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_tests++;
            if ({clk_px_def, stb_def, srst_def, clk_px_fast, stb_fast, srst_fast,
                 clk_px_s5, stb_s5, srst_s5} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d got %b%b%b %b%b%b %b%b%b exp all 0", k,
                         clk_px_def, stb_def, srst_def, clk_px_fast, stb_fast, srst_fast,
                         clk_px_s5, stb_s5, srst_s5);
            end
        end
    endtask

    task automatic test_release();
        run_release_seq("release");
    endtask

    // One-cycle reset pulse mid-operation restarts the whole sequence.
    task automatic test_mid_reset();
        // land the pulse where clk_px is high and the synchroniser is released
        for (int k = 0; k < 3; k++) step();
        rstn = 1'b0;
        step();
        n_tests++;
        if ({clk_px_def, stb_def, srst_def, clk_px_s5, srst_s5, clk_px_fast, srst_fast} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset outputs got %b%b%b %b%b %b%b exp all 0",
                     clk_px_def, stb_def, srst_def, clk_px_s5, srst_s5, clk_px_fast, srst_fast);
        end
        run_release_seq("mid_reset");
    endtask

    // Colour mux sweep on the 3-bit instance, plus mono spot checks.
    task automatic test_colour_mux();
        logic [2:0] exp3 [6];
        logic [2:0] mv   [6];
        logic [2:0] tv   [6];
        logic       ev   [6];
        logic       bv   [6];
        // blank=0 both sources, test sel, mem sel, mem=X sel test, test=X sel mem
        bv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'bxxx};
        mv = '{3'b010, 3'b010, 3'b010, 3'b010, 3'bxxx, 3'b010};
        exp3 = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b101, 3'b010};
        for (int i = 0; i < 6; i++) begin
            test3 = tv[i]; mem3 = mv[i]; en3 = ev[i]; blank3 = bv[i];
            #1;
            n_tests++;
            if (colr_s5 !== exp3[i]) begin
                n_fail++;
                $display("FAIL mux3 vec%0d got %b exp %b", i, colr_s5, exp3[i]);
            end
        end
        // mono: test=1, mem=0
        test1 = 1'b1; mem1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] sel;
            logic       e;
            sel = 2'(i);
            blank1 = sel[1]; en1 = sel[0];
            e = sel[1] ? sel[0] : 1'b0;
            #1;
            n_tests++;
            if (colr_def !== e || colr_fast !== e) begin
                n_fail++;
                $display("FAIL mux1 blank%b en%b got %b/%b exp %b", sel[1], sel[0], colr_def, colr_fast, e);
            end
        end
    endtask

    // Colour path ignores reset.
    task automatic test_mux_in_reset();
        rstn = 1'b0;
        step();
        test3 = 3'b110; mem3 = 3'b011; blank3 = 1'b1; en3 = 1'b0;
        #1;
        n_tests++;
        if (colr_s5 !== 3'b011) begin
            n_fail++;
            $display("FAIL mux_in_reset got %b exp 011", colr_s5);
        end
        en3 = 1'b1;
        #1;
        n_tests++;
        if (colr_s5 !== 3'b110) begin
            n_fail++;
            $display("FAIL mux_in_reset_test got %b exp 110", colr_s5);
        end
    endtask

    initial begin
        rstn = 1'b0;
        test1 = 1'b0; mem1 = 1'b0; en1 = 1'b0; blank1 = 1'b0;
        test3 = 3'b0; mem3 = 3'b0; en3 = 1'b0; blank3 = 1'b0;
        #2;
        test_reset();
        test_release();
        test_mid_reset();
        test_colour_mux();
        test_mux_in_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
